// File: rtl/parallel_serial_converter_bp_pkg.sv
// rtl/parallel_serial_converter_bp_pkg.sv - shared types for the egress wide-to-narrow serializer
package parallel_serial_converter_bp_pkg;

    // Width of the length field: index of the last valid beat of an EOF word
    localparam int LEN_W = 8;

    typedef struct packed {
        logic             start_of_frame;
        logic             end_of_frame;
        logic [LEN_W-1:0] length;
    } info_type;

    typedef enum logic {
        PSC_IDLE,
        PSC_SEND
    } psc_state_t;

    // Index of the last beat to emit for a word; oversize lengths saturate at max_idx
    function automatic logic [LEN_W-1:0] last_beat_index(input info_type info,
                                                         input logic [LEN_W-1:0] max_idx);
        if (!info.end_of_frame || (info.length > max_idx)) begin
            return max_idx;
        end
        return info.length;
    endfunction

endpackage

// File: rtl/parallel_serial_converter_bp_async_fifo.sv
// rtl/parallel_serial_converter_bp_async_fifo.sv - gray-pointer dual-clock FIFO with show-ahead read
module parallel_serial_converter_bp_async_fifo #(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic         wclk,
    input  logic         rclk,
    input  logic         rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         multi
);

    localparam int DEPTH = 1 << A;

    function automatic logic [A:0] bin2gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W-1:0] mem_q [DEPTH];

    logic [A:0] w_bin_q, w_bin_d, w_gray_q;
    logic [A:0] rg_s1_q, rg_s2_q, rs_bin;
    logic [A:0] r_bin_q, r_bin_d, r_gray_q;
    logic [A:0] wg_s1_q, wg_s2_q, ws_bin, level;
    logic       wr_fire, rd_fire;

    // Write side: full when the synced read pointer is exactly one lap behind
    always_comb begin
        rs_bin  = gray2bin(rg_s2_q);
        full    = (w_bin_q[A] != rs_bin[A]) && (w_bin_q[A-1:0] == rs_bin[A-1:0]);
        wr_fire = wr_en && !full;
        w_bin_d = w_bin_q + {{A{1'b0}}, wr_fire};
    end

    // Write pointer plus two-flop sync of the read pointer into wclk
    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            w_bin_q  <= '0;
            w_gray_q <= '0;
            rg_s1_q  <= '0;
            rg_s2_q  <= '0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_gray_q <= bin2gray(w_bin_d);
            rg_s1_q  <= r_gray_q;
            rg_s2_q  <= rg_s1_q;
        end
    end

    // Storage; written only when a slot is known free so no reset is needed
    always_ff @(posedge wclk) begin
        if (wr_fire) begin
            mem_q[w_bin_q[A-1:0]] <= wr_data;
        end
    end

    // Read side: level from the synced write pointer; multi lets the reader chain words without a gap
    always_comb begin
        ws_bin  = gray2bin(wg_s2_q);
        level   = ws_bin - r_bin_q;
        empty   = (level == '0);
        multi   = (level > (A+1)'(1));
        rd_fire = rd_en && !empty;
        r_bin_d = r_bin_q + {{A{1'b0}}, rd_fire};
        rd_data = mem_q[r_bin_q[A-1:0]];
    end

    // Read pointer plus two-flop sync of the write pointer into rclk
    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_bin_q  <= '0;
            r_gray_q <= '0;
            wg_s1_q  <= '0;
            wg_s2_q  <= '0;
        end else begin
            r_bin_q  <= r_bin_d;
            r_gray_q <= bin2gray(r_bin_d);
            wg_s1_q  <= w_gray_q;
            wg_s2_q  <= wg_s1_q;
        end
    end

endmodule

// File: rtl/parallel_serial_converter_bp.sv
// rtl/parallel_serial_converter_bp.sv - wide word to narrow beat serializer with backpressure and framing
module parallel_serial_converter_bp
    import parallel_serial_converter_bp_pkg::*;
#(
    parameter int parallelWidth = 512,
    parameter int serialWidth   = 8,
    parameter int fifoAddrW     = 4
) (
    input  logic                     popClk,
    input  logic                     rstn,
    input  logic                     clk,
    input  logic                     push,
    input  logic [parallelWidth-1:0] pushData,
    input  info_type                 pushInfo,
    input  logic                     pushError,
    output logic                     full,
    output logic                     overflow,
    input  logic                     popReady,
    output logic                     popDataPresent,
    output logic [serialWidth-1:0]   popData,
    output logic                     popDataStartOfFrame,
    output logic                     popDataEndOfFrame,
    output logic                     popDataError
);

    localparam int LANES  = parallelWidth / serialWidth;
    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int INFO_W = $bits(info_type);
    localparam int FIFO_W = parallelWidth + INFO_W + 1;

    if ((parallelWidth % serialWidth) != 0) begin : g_width_check
        $error("parallelWidth must be a multiple of serialWidth");
    end
    if (LANES > (1 << LEN_W)) begin : g_len_check
        $error("length field too narrow for the number of lanes");
    end

    logic                     overflow_q, overflow_d;
    logic [FIFO_W-1:0]        fifo_wr_data, fifo_rd_data;
    logic                     fifo_empty, fifo_multi, fifo_pop;
    logic [parallelWidth-1:0] rd_word;
    info_type                 rd_info;
    logic                     rd_err;
    logic [serialWidth-1:0]   beats [LANES];
    logic [LEN_W-1:0]         last_idx_w;
    logic [CNT_W-1:0]         last_idx;
    logic                     slot_free;

    psc_state_t               state_q, state_d;
    logic [CNT_W-1:0]         counter_q, counter_d;
    logic                     err_acc_q, err_acc_d;
    logic                     present_q, present_d;
    logic [serialWidth-1:0]   data_q, data_d;
    logic                     sof_q, sof_d;
    logic                     eof_q, eof_d;
    logic                     err_q, err_d;

    assign fifo_wr_data = {pushData, pushInfo, pushError};

    parallel_serial_converter_bp_async_fifo #(
        .W (FIFO_W),
        .A (fifoAddrW)
    ) u_fifo (
        .wclk    (clk),
        .rclk    (popClk),
        .rstn    (rstn),
        .wr_en   (push),
        .wr_data (fifo_wr_data),
        .full    (full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .multi   (fifo_multi)
    );

    // A push against a full FIFO is dropped and flagged for one core cycle
    always_comb begin
        overflow_d = push && full;
    end

    // Overflow flag register in the core domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    assign {rd_word, rd_info, rd_err} = fifo_rd_data;

    for (genvar k = 0; k < LANES; k++) begin : g_beat
        assign beats[k] = rd_word[k*serialWidth +: serialWidth];
    end

    assign last_idx_w = last_beat_index(rd_info, LEN_W'(LANES - 1));
    assign last_idx   = last_idx_w[CNT_W-1:0];
    assign slot_free  = !present_q || popReady;

    // Next-state: load one beat per free output slot, pop on the last beat of each word
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        err_acc_d = err_acc_q;
        present_d = present_q;
        data_d    = data_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        err_d     = err_q;
        fifo_pop  = 1'b0;
        if (slot_free) begin
            present_d = 1'b0;
            data_d    = '0;
            sof_d     = 1'b0;
            eof_d     = 1'b0;
            err_d     = 1'b0;
        end
        case (state_q)
            PSC_IDLE: begin
                if (!fifo_empty) begin
                    state_d = PSC_SEND;
                end
            end
            PSC_SEND: begin
                if (slot_free) begin
                    present_d = 1'b1;
                    data_d    = beats[counter_q];
                    sof_d     = rd_info.start_of_frame && (counter_q == '0);
                    if (counter_q == last_idx) begin
                        fifo_pop  = 1'b1;
                        counter_d = '0;
                        if (rd_info.end_of_frame) begin
                            eof_d     = 1'b1;
                            err_d     = err_acc_q | rd_err;
                            err_acc_d = 1'b0;
                            state_d   = PSC_IDLE;
                        end else begin
                            err_acc_d = err_acc_q | rd_err;
                            state_d   = fifo_multi ? PSC_SEND : PSC_IDLE;
                        end
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = PSC_IDLE;
            end
        endcase
    end

    // FSM, beat counter, error accumulator and registered output beat
    always_ff @(posedge popClk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= PSC_IDLE;
            counter_q <= '0;
            err_acc_q <= 1'b0;
            present_q <= 1'b0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            err_acc_q <= err_acc_d;
            present_q <= present_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
        end
    end

    assign popDataPresent      = present_q;
    assign popData             = data_q;
    assign popDataStartOfFrame = sof_q;
    assign popDataEndOfFrame   = eof_q;
    assign popDataError        = err_q;

endmodule

// File: tb/tb_parallel_serial_converter_bp.sv
// tb/tb_parallel_serial_converter_bp.sv - directed self-checking bench for the serializer
module tb_parallel_serial_converter_bp;
    import parallel_serial_converter_bp_pkg::*;

    logic         clk = 1'b0;
    logic         popClk = 1'b0;
    logic         rstn;
    logic         push;
    logic [511:0] pushData;
    info_type     pushInfo;
    logic         pushError;
    logic         full;
    logic         overflow;
    logic         popReady;
    logic         popDataPresent;
    logic [7:0]   popData;
    logic         popDataStartOfFrame;
    logic         popDataEndOfFrame;
    logic         popDataError;

    int vectors = 0;
    int miscompares = 0;
    int pop_cycles = 0;

    logic [7:0] cap_data [256];
    logic       cap_sof  [256];
    logic       cap_eof  [256];
    logic       cap_err  [256];
    int         cap_cyc  [256];

    parallel_serial_converter_bp #(
        .parallelWidth (512),
        .serialWidth   (8),
        .fifoAddrW     (4)
    ) dut (
        .popClk              (popClk),
        .rstn                (rstn),
        .clk                 (clk),
        .push                (push),
        .pushData            (pushData),
        .pushInfo            (pushInfo),
        .pushError           (pushError),
        .full                (full),
        .overflow            (overflow),
        .popReady            (popReady),
        .popDataPresent      (popDataPresent),
        .popData             (popData),
        .popDataStartOfFrame (popDataStartOfFrame),
        .popDataEndOfFrame   (popDataEndOfFrame),
        .popDataError        (popDataError)
    );

    always #5 clk = ~clk;
    always #6 popClk = ~popClk;
    always @(posedge popClk) pop_cycles++;

    // Push one word whose beat k is base+k
    task automatic push_word(input logic [7:0] base, input logic sof, input logic eof,
                             input logic [7:0] len, input logic err);
        info_type inf;
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) begin
            pushData[k*8 +: 8] = base + 8'(k);
        end
        inf.start_of_frame = sof;
        inf.end_of_frame   = eof;
        inf.length         = len;
        pushInfo  = inf;
        pushError = err;
        push      = 1'b1;
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    task automatic record_beat(inout int got);
        if (got < 256) begin
            cap_data[got] = popData;
            cap_sof[got]  = popDataStartOfFrame;
            cap_eof[got]  = popDataEndOfFrame;
            cap_err[got]  = popDataError;
            cap_cyc[got]  = pop_cycles;
        end
        got++;
    endtask

    // Drain with popReady=1 until n beats or max_cyc cycles, then keep watching for extra cycles
    task automatic collect(input int n, input int max_cyc, input int extra, output int got);
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < max_cyc) begin
            @(posedge popClk);
            #1 popReady = 1'b1;
            @(negedge popClk);
            if (popDataPresent && popReady) record_beat(got);
            cyc++;
        end
        for (int i = 0; i < extra; i++) begin
            @(posedge popClk);
            #1 popReady = 1'b1;
            @(negedge popClk);
            if (popDataPresent && popReady) record_beat(got);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        push = 1'b0;
        pushData = '0;
        pushInfo = '0;
        pushError = 1'b0;
        popReady = 1'b0;
        #20;
        vectors++; if (popDataPresent !== 1'b0) begin miscompares++; $display("FAIL reset_present got %0b expected 0", popDataPresent); end
        vectors++; if (popData !== 8'h00) begin miscompares++; $display("FAIL reset_data got %0h expected 00", popData); end
        vectors++; if (popDataStartOfFrame !== 1'b0) begin miscompares++; $display("FAIL reset_sof got %0b expected 0", popDataStartOfFrame); end
        vectors++; if (popDataEndOfFrame !== 1'b0) begin miscompares++; $display("FAIL reset_eof got %0b expected 0", popDataEndOfFrame); end
        vectors++; if (popDataError !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b expected 0", popDataError); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b expected 0", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b expected 0", overflow); end
        #13 rstn = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single_word();
        int got;
        popReady = 1'b0;
        push_word(8'h00, 1'b1, 1'b1, 8'd63, 1'b0);
        collect(64, 400, 20, got);
        vectors++; if (got !== 64) begin miscompares++; $display("FAIL single_count got %0d expected 64", got); end
        for (int k = 0; k < 64 && k < got; k++) begin
            vectors++; if (cap_data[k] !== 8'(k)) begin miscompares++; $display("FAIL single_data beat %0d got %0h expected %0h", k, cap_data[k], 8'(k)); end
            vectors++; if (cap_sof[k] !== (k == 0)) begin miscompares++; $display("FAIL single_sof beat %0d got %0b", k, cap_sof[k]); end
            vectors++; if (cap_eof[k] !== (k == 63)) begin miscompares++; $display("FAIL single_eof beat %0d got %0b", k, cap_eof[k]); end
            vectors++; if (cap_err[k] !== 1'b0) begin miscompares++; $display("FAIL single_err beat %0d got %0b expected 0", k, cap_err[k]); end
        end
        if (got >= 64) begin
            vectors++; if (cap_cyc[63] - cap_cyc[0] !== 63) begin miscompares++; $display("FAIL single_span got %0d expected 63", cap_cyc[63] - cap_cyc[0]); end
        end
    endtask

    task automatic test_two_word_frame();
        int got;
        logic [7:0] exp_b;
        popReady = 1'b0;
        push_word(8'h10, 1'b1, 1'b0, 8'd5, 1'b0);
        push_word(8'h80, 1'b0, 1'b1, 8'd5, 1'b0);
        collect(70, 400, 20, got);
        vectors++; if (got !== 70) begin miscompares++; $display("FAIL two_count got %0d expected 70", got); end
        for (int k = 0; k < 70 && k < got; k++) begin
            exp_b = (k < 64) ? 8'h10 + 8'(k) : 8'h80 + 8'(k - 64);
            vectors++; if (cap_data[k] !== exp_b) begin miscompares++; $display("FAIL two_data beat %0d got %0h expected %0h", k, cap_data[k], exp_b); end
            vectors++; if (cap_sof[k] !== (k == 0)) begin miscompares++; $display("FAIL two_sof beat %0d got %0b", k, cap_sof[k]); end
            vectors++; if (cap_eof[k] !== (k == 69)) begin miscompares++; $display("FAIL two_eof beat %0d got %0b", k, cap_eof[k]); end
        end
        if (got >= 70) begin
            vectors++; if (cap_cyc[69] - cap_cyc[0] !== 69) begin miscompares++; $display("FAIL two_gapless got %0d expected 69", cap_cyc[69] - cap_cyc[0]); end
        end
    endtask

    task automatic test_length_clamp();
        int got;
        popReady = 1'b0;
        push_word(8'h40, 1'b1, 1'b1, 8'd200, 1'b0);
        collect(64, 400, 20, got);
        vectors++; if (got !== 64) begin miscompares++; $display("FAIL clamp_count got %0d expected 64", got); end
        if (got >= 64) begin
            vectors++; if (cap_data[63] !== 8'h7F) begin miscompares++; $display("FAIL clamp_last_data got %0h expected 7f", cap_data[63]); end
            vectors++; if (cap_eof[63] !== 1'b1) begin miscompares++; $display("FAIL clamp_eof got %0b expected 1", cap_eof[63]); end
        end
    endtask

    task automatic test_backpressure();
        int got;
        int cyc;
        logic stalled;
        logic [7:0] prev_data;
        logic prev_sof, prev_eof;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_data = '0;
        prev_sof = 1'b0;
        prev_eof = 1'b0;
        popReady = 1'b0;
        push_word(8'h20, 1'b1, 1'b1, 8'd15, 1'b0);
        while (got < 16 && cyc < 300) begin
            @(posedge popClk);
            #1 popReady = ~popReady;
            @(negedge popClk);
            if (stalled) begin
                vectors++; if (popDataPresent !== 1'b1) begin miscompares++; $display("FAIL stall_present got %0b expected 1", popDataPresent); end
                vectors++; if (popData !== prev_data) begin miscompares++; $display("FAIL stall_data got %0h expected %0h", popData, prev_data); end
                vectors++; if (popDataStartOfFrame !== prev_sof || popDataEndOfFrame !== prev_eof) begin miscompares++; $display("FAIL stall_flags got %0b%0b expected %0b%0b", popDataStartOfFrame, popDataEndOfFrame, prev_sof, prev_eof); end
            end
            stalled = popDataPresent && !popReady;
            prev_data = popData;
            prev_sof = popDataStartOfFrame;
            prev_eof = popDataEndOfFrame;
            if (popDataPresent && popReady) record_beat(got);
            cyc++;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge popClk);
            #1 popReady = 1'b1;
            @(negedge popClk);
            if (popDataPresent && popReady) record_beat(got);
        end
        vectors++; if (got !== 16) begin miscompares++; $display("FAIL bp_count got %0d expected 16", got); end
        for (int k = 0; k < 16 && k < got; k++) begin
            vectors++; if (cap_data[k] !== 8'h20 + 8'(k)) begin miscompares++; $display("FAIL bp_data beat %0d got %0h expected %0h", k, cap_data[k], 8'h20 + 8'(k)); end
            vectors++; if (cap_sof[k] !== (k == 0) || cap_eof[k] !== (k == 15)) begin miscompares++; $display("FAIL bp_flags beat %0d got %0b%0b", k, cap_sof[k], cap_eof[k]); end
        end
    endtask

    task automatic test_overflow();
        int got;
        popReady = 1'b0;
        push_word(8'h00, 1'b1, 1'b1, 8'd0, 1'b0);
        repeat (20) @(posedge clk);
        for (int i = 1; i <= 16; i++) begin
            push_word(8'(i), 1'b1, 1'b1, 8'd0, 1'b0);
            if (i == 15) begin
                vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL full_at_15 got %0b expected 0", full); end
            end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_at_16 got %0b expected 1", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_before got %0b expected 0", overflow); end
        push_word(8'hEE, 1'b1, 1'b1, 8'd0, 1'b0);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_pulse got %0b expected 1", overflow); end
        @(posedge clk);
        #1;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_clear got %0b expected 0", overflow); end
        collect(17, 300, 40, got);
        vectors++; if (got !== 17) begin miscompares++; $display("FAIL ovf_count got %0d expected 17", got); end
        for (int k = 0; k < 17 && k < got; k++) begin
            vectors++; if (cap_data[k] !== 8'(k)) begin miscompares++; $display("FAIL ovf_data beat %0d got %0h expected %0h", k, cap_data[k], 8'(k)); end
            vectors++; if (cap_sof[k] !== 1'b1 || cap_eof[k] !== 1'b1) begin miscompares++; $display("FAIL ovf_flags beat %0d got %0b%0b expected 11", k, cap_sof[k], cap_eof[k]); end
        end
    endtask

    task automatic test_error_propagation();
        int got;
        logic [7:0] exp_b;
        popReady = 1'b0;
        push_word(8'h00, 1'b1, 1'b0, 8'd0, 1'b0);
        push_word(8'h40, 1'b0, 1'b0, 8'd0, 1'b1);
        push_word(8'h80, 1'b0, 1'b1, 8'd3, 1'b0);
        push_word(8'hC0, 1'b1, 1'b1, 8'd1, 1'b0);
        collect(134, 600, 20, got);
        vectors++; if (got !== 134) begin miscompares++; $display("FAIL err_count got %0d expected 134", got); end
        for (int k = 0; k < 134 && k < got; k++) begin
            if (k < 64) exp_b = 8'(k);
            else if (k < 128) exp_b = 8'h40 + 8'(k - 64);
            else if (k < 132) exp_b = 8'h80 + 8'(k - 128);
            else exp_b = 8'hC0 + 8'(k - 132);
            vectors++; if (cap_data[k] !== exp_b) begin miscompares++; $display("FAIL err_data beat %0d got %0h expected %0h", k, cap_data[k], exp_b); end
            vectors++; if (cap_err[k] !== (k == 131)) begin miscompares++; $display("FAIL err_flag beat %0d got %0b", k, cap_err[k]); end
            vectors++; if (cap_eof[k] !== (k == 131 || k == 133)) begin miscompares++; $display("FAIL err_eof beat %0d got %0b", k, cap_eof[k]); end
            vectors++; if (cap_sof[k] !== (k == 0 || k == 132)) begin miscompares++; $display("FAIL err_sof beat %0d got %0b", k, cap_sof[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int got;
        popReady = 1'b0;
        push_word(8'h00, 1'b1, 1'b1, 8'd63, 1'b0);
        collect(20, 300, 0, got);
        vectors++; if (got !== 20) begin miscompares++; $display("FAIL mid_pre_count got %0d expected 20", got); end
        #3 rstn = 1'b0;
        #1;
        vectors++; if (popDataPresent !== 1'b0) begin miscompares++; $display("FAIL mid_rst_present got %0b expected 0", popDataPresent); end
        vectors++; if (popData !== 8'h00) begin miscompares++; $display("FAIL mid_rst_data got %0h expected 00", popData); end
        vectors++; if (popDataStartOfFrame !== 1'b0 || popDataEndOfFrame !== 1'b0 || popDataError !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flags got %0b%0b%0b expected 000", popDataStartOfFrame, popDataEndOfFrame, popDataError); end
        popReady = 1'b0;
        repeat (3) @(posedge popClk);
        @(negedge popClk);
        #2 rstn = 1'b1;
        push_word(8'h50, 1'b1, 1'b1, 8'd3, 1'b0);
        collect(4, 300, 30, got);
        vectors++; if (got !== 4) begin miscompares++; $display("FAIL mid_post_count got %0d expected 4", got); end
        for (int k = 0; k < 4 && k < got; k++) begin
            vectors++; if (cap_data[k] !== 8'h50 + 8'(k)) begin miscompares++; $display("FAIL mid_post_data beat %0d got %0h expected %0h", k, cap_data[k], 8'h50 + 8'(k)); end
            vectors++; if (cap_sof[k] !== (k == 0) || cap_eof[k] !== (k == 3)) begin miscompares++; $display("FAIL mid_post_flags beat %0d got %0b%0b", k, cap_sof[k], cap_eof[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_word_frame();
        test_length_clamp();
        test_backpressure();
        test_overflow();
        test_error_propagation();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
